// File: rtl/aes128_iter_core_pkg.sv
// aes_pkg: AES-128 constant tables, GF(2^8) helpers and the core FSM state type
package aes_pkg;
    localparam int AES_NR = 10;
    typedef enum logic [1:0] {IDLE, RUN, DONE} aes_state_t;
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // 2a^3b^c^d written as a ^ (a^b^c^d) ^ 2(a^b) to share one xtime per output byte
    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3, t;
        {a0, a1, a2, a3} = c;
        t = a0 ^ a1 ^ a2 ^ a3;
        return {a0 ^ t ^ xtime(a0 ^ a1), a1 ^ t ^ xtime(a1 ^ a2),
                a2 ^ t ^ xtime(a2 ^ a3), a3 ^ t ^ xtime(a3 ^ a0)};
    endfunction
endpackage

// File: rtl/aes128_iter_core_if.sv
// aes128_iter_core_if: plaintext/key input and ciphertext output handshake bus
interface aes128_iter_core_if;
    logic         AES_in_valid;
    logic         AES_in_ready;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic [127:0] AES_data_out;
    logic         AES_data_out_valid;
    logic         AES_out_ready;
    logic         AES_busy;

    modport slave (
        input  AES_in_valid, AES_data_in, AES_key_in, AES_out_ready,
        output AES_in_ready, AES_data_out, AES_data_out_valid, AES_busy
    );
    modport master (
        output AES_in_valid, AES_data_in, AES_key_in, AES_out_ready,
        input  AES_in_ready, AES_data_out, AES_data_out_valid, AES_busy
    );
endinterface

// File: rtl/aes128_iter_core_round.sv
// aes_round: one combinational AES-128 round together with its key-expansion step
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    input  logic         last,
    output logic [127:0] state_nxt,
    output logic [127:0] rk_nxt
);
    logic [31:0]  t, w0, w1, w2, w3;
    logic [127:0] sr, mc;

    assign t  = sub_word(rot_word(rk[31:0])) ^ {rcon, 24'h0};
    assign w0 = rk[127:96] ^ t;
    assign w1 = rk[95:64] ^ w0;
    assign w2 = rk[63:32] ^ w1;
    assign w3 = rk[31:0] ^ w2;
    assign rk_nxt = {w0, w1, w2, w3};

    // byte i sits at row i%4, column i/4; ShiftRows pulls from column (col+row)%4
    always_comb begin
        sr = '0;
        mc = '0;
        for (int i = 0; i < 16; i++)
            sr[127 - 8*i -: 8] = SBOX[state[127 - 8*(4*((i/4 + i%4) % 4) + i%4) -: 8]];
        for (int c = 0; c < 4; c++)
            mc[127 - 32*c -: 32] = last ? sr[127 - 32*c -: 32] : mix_column(sr[127 - 32*c -: 32]);
    end

    assign state_nxt = mc ^ rk_nxt;
endmodule

// File: rtl/aes128_iter_core.sv
// aes128_iter_core: iterative AES-128 encryptor, UNROLL rounds per clock,
// on-the-fly key expansion and valid/ready handshake on both sides.
module aes128_iter_core
    import aes_pkg::*;
#(
    parameter int UNROLL        = 1,
    parameter bit CLEAR_ON_DONE = 1
) (
    input logic               AES_clk,
    input logic               AES_rst_n,
    aes128_iter_core_if.slave bus
);
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
        $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
    end

    aes_state_t   fsm_q, fsm_d;
    logic [127:0] blk_q, blk_d, rk_q, rk_d, dout_q, dout_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         accept;
    logic [127:0] st_c [UNROLL+1];
    logic [127:0] rk_c [UNROLL+1];

    assign st_c[0] = blk_q;
    assign rk_c[0] = rk_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
        logic [3:0] idx;
        assign idx = rnd_q + 4'(g);
        aes_round u_round (
            .state     (st_c[g]),
            .rk        (rk_c[g]),
            .rcon      (idx < 4'(AES_NR) ? RCON[idx] : 8'h00),
            .last      (idx == 4'(AES_NR - 1)),
            .state_nxt (st_c[g+1]),
            .rk_nxt    (rk_c[g+1])
        );
    end

    assign bus.AES_in_ready       = fsm_q == IDLE || (fsm_q == DONE && bus.AES_out_ready);
    assign bus.AES_data_out       = dout_q;
    assign bus.AES_data_out_valid = fsm_q == DONE;
    assign bus.AES_busy           = fsm_q != IDLE;
    assign accept                 = bus.AES_in_valid && bus.AES_in_ready;

    // a new accept in DONE overrides the handshake's return to IDLE
    always_comb begin
        fsm_d  = fsm_q;
        blk_d  = blk_q;
        rk_d   = rk_q;
        rnd_d  = rnd_q;
        dout_d = dout_q;
        if (fsm_q == RUN) begin
            blk_d  = st_c[UNROLL];
            rk_d   = rk_c[UNROLL];
            rnd_d  = rnd_q + 4'(UNROLL);
            fsm_d  = rnd_d == 4'(AES_NR) ? DONE : RUN;
            dout_d = rnd_d == 4'(AES_NR) ? st_c[UNROLL] : dout_q;
        end
        if (fsm_q == DONE && bus.AES_out_ready) begin
            fsm_d = IDLE;
            if (CLEAR_ON_DONE) begin
                blk_d  = '0;
                rk_d   = '0;
                dout_d = '0;
            end
        end
        if (accept) begin
            fsm_d = RUN;
            blk_d = bus.AES_data_in ^ bus.AES_key_in;
            rk_d  = bus.AES_key_in;
            rnd_d = '0;
        end
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            fsm_q  <= IDLE;
            blk_q  <= '0;
            rk_q   <= '0;
            rnd_q  <= '0;
            dout_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            blk_q  <= blk_d;
            rk_q   <= rk_d;
            rnd_q  <= rnd_d;
            dout_q <= dout_d;
        end
    end
endmodule

// File: tb/tb_aes128_iter_core.sv
// tb_aes128_iter_core: scoreboard bench for aes128_iter_core using FIPS-197 vectors
// and an independent software AES model (S-box derived from GF(2^8) inversion).
module tb_aes128_iter_core;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         rst_u_n = 1'b0;
    int           total   = 0;
    int           bad     = 0;
    int           u_done  = 0;
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;
    initial #12 rst_u_n = 1'b1;

    aes128_iter_core_if bus ();
    aes128_iter_core #(.UNROLL(1), .CLEAR_ON_DONE(1)) dut (
        .AES_clk   (clk),
        .AES_rst_n (rst_n),
        .bus       (bus)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return 8'h63 ^ inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                     ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]};
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   k [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [127:0] r;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127 - 8*i -: 8];
            s[i] = pt[127 - 8*i -: 8] ^ k[i];
        end
        for (int n = 1; n <= 10; n++) begin
            t[0] = sbox_m(k[13]) ^ rc;
            t[1] = sbox_m(k[14]);
            t[2] = sbox_m(k[15]);
            t[3] = sbox_m(k[12]);
            for (int i = 0; i < 4; i++) k[i] ^= t[i];
            for (int i = 4; i < 16; i++) k[i] ^= k[i-4];
            rc = gmul(rc, 8'h02);
            for (int i = 0; i < 16; i++) t[i] = sbox_m(s[(i + 4*(i%4)) % 16]);
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    s[4*c+j] = (n == 10) ? t[4*c+j] :
                        gmul(t[4*c+j], 8'h02) ^ gmul(t[4*c+(j+1)%4], 8'h03) ^ t[4*c+(j+2)%4] ^ t[4*c+(j+3)%4];
            for (int i = 0; i < 16; i++) s[i] ^= k[i];
        end
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = s[i];
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.AES_data_out_valid && bus.AES_out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_spurious: got %h expected no output", bus.AES_data_out);
            end else begin
                check("sb_data", bus.AES_data_out, exp_q.pop_front());
            end
        end
    end

    // called just after a rising edge; returns just after the accept edge
    task automatic send(input logic [127:0] pt, input logic [127:0] key,
                        input logic [127:0] exp, input bit push);
        int n = 0;
        bus.AES_data_in  = pt;
        bus.AES_key_in   = key;
        bus.AES_in_valid = 1'b1;
        while (!bus.AES_in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_ready", 128'(bus.AES_in_ready), 128'd1);
        @(posedge clk);
        if (push) exp_q.push_back(exp);
        #1 bus.AES_in_valid = 1'b0;
    endtask

    task automatic wait_valid(input bit toggle, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (toggle) begin
                bus.AES_data_in = {$urandom, $urandom, $urandom, $urandom};
                bus.AES_key_in  = {$urandom, $urandom, $urandom, $urandom};
            end
        end while (!bus.AES_data_out_valid && cyc < 50);
    endtask

    initial begin
        int cyc;
        int n;
        bus.AES_in_valid  = 1'b1;
        bus.AES_data_in   = PT_B;
        bus.AES_key_in    = KEY_B;
        bus.AES_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", bus.AES_data_out, 128'd0);
        check("rst_valid", 128'(bus.AES_data_out_valid), 128'd0);
        check("rst_busy", 128'(bus.AES_busy), 128'd0);
        check("rst_in_ready", 128'(bus.AES_in_ready), 128'd1);
        rst_n = 1'b1;

        send(PT_B, KEY_B, CT_B, 1'b1);
        check("busy_run", 128'(bus.AES_busy), 128'd1);
        wait_valid(1'b1, cyc);
        check("lat_b", 128'(cyc), 128'd10);
        @(posedge clk);
        #1;
        check("idle_valid", 128'(bus.AES_data_out_valid), 128'd0);
        check("idle_dout", bus.AES_data_out, 128'd0);
        check("idle_busy", 128'(bus.AES_busy), 128'd0);

        send(PT_C, KEY_C, CT_C, 1'b1);
        wait_valid(1'b1, cyc);
        check("lat_c", 128'(cyc), 128'd10);
        @(posedge clk);
        #1;

        bus.AES_out_ready = 1'b0;
        send(PT_C, KEY_C, CT_C, 1'b1);
        wait_valid(1'b0, cyc);
        bus.AES_in_valid = 1'b1;
        bus.AES_data_in  = PT_B;
        bus.AES_key_in   = KEY_B;
        repeat (20) begin
            @(posedge clk);
            #1;
            check("bp_dout", bus.AES_data_out, CT_C);
            check("bp_valid", 128'(bus.AES_data_out_valid), 128'd1);
            check("bp_in_ready", 128'(bus.AES_in_ready), 128'd0);
        end
        bus.AES_in_valid  = 1'b0;
        bus.AES_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_valid_clr", 128'(bus.AES_data_out_valid), 128'd0);
        check("bp_dout_zero", bus.AES_data_out, 128'd0);
        check("bp_busy", 128'(bus.AES_busy), 128'd0);

        send(PT_B, KEY_B, CT_B, 1'b1);
        bus.AES_data_in  = PT_C;
        bus.AES_key_in   = KEY_C;
        bus.AES_in_valid = 1'b1;
        wait_valid(1'b0, cyc);
        check("b2b_in_ready", 128'(bus.AES_in_ready), 128'd1);
        exp_q.push_back(CT_C);
        @(posedge clk);
        #1 bus.AES_in_valid = 1'b0;
        wait_valid(1'b0, cyc);
        check("b2b_gap", 128'(cyc + 1), 128'd11);
        @(posedge clk);
        #1;

        send(PT_B, KEY_B, CT_B, 1'b1);
        wait_valid(1'b0, cyc);
        @(posedge clk);
        #1;
        send(PT_B, KEY_C, aes_model(PT_B, KEY_C), 1'b1);
        wait_valid(1'b0, cyc);
        check("lat_kc", 128'(cyc), 128'd10);
        @(posedge clk);
        #1;

        send(PT_C, KEY_C, CT_C, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_dout", bus.AES_data_out, 128'd0);
        check("mid_rst_valid", 128'(bus.AES_data_out_valid), 128'd0);
        check("mid_rst_busy", 128'(bus.AES_busy), 128'd0);
        check("mid_rst_in_ready", 128'(bus.AES_in_ready), 128'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_valid(1'b0, cyc);
        check("no_valid_after_rst", 128'(bus.AES_data_out_valid), 128'd0);
        send(PT_C, KEY_C, CT_C, 1'b1);
        wait_valid(1'b0, cyc);
        check("lat_after_rst", 128'(cyc), 128'd10);
        @(posedge clk);
        #1;

        n = 0;
        while (u_done < 3 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("unroll_done", 128'(u_done), 128'd3);
        check("sb_drained", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    for (genvar g = 0; g < 3; g++) begin : g_unroll
        localparam int U = (g == 0) ? 2 : (g == 1) ? 5 : 10;
        aes128_iter_core_if ub ();
        aes128_iter_core #(.UNROLL(U), .CLEAR_ON_DONE(0)) udut (
            .AES_clk   (clk),
            .AES_rst_n (rst_u_n),
            .bus       (ub)
        );
        initial begin
            int cyc;
            ub.AES_in_valid  = 1'b1;
            ub.AES_data_in   = PT_B;
            ub.AES_key_in    = KEY_B;
            ub.AES_out_ready = 1'b0;
            wait (rst_u_n);
            @(posedge clk);
            #1 ub.AES_in_valid = 1'b0;
            cyc = 0;
            do begin
                @(posedge clk);
                #1;
                cyc++;
            end while (!ub.AES_data_out_valid && cyc < 30);
            check($sformatf("lat_u%0d", U), 128'(cyc), 128'(10 / U));
            check($sformatf("ct_u%0d", U), ub.AES_data_out, CT_B);
            ub.AES_out_ready = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("noclr_valid_u%0d", U), 128'(ub.AES_data_out_valid), 128'd0);
            check($sformatf("noclr_dout_u%0d", U), ub.AES_data_out, CT_B);
            u_done++;
        end
    end
endmodule
